// File: rtl/pong_pkg.sv
// pong_pkg: FSM state encoding, screen/paddle geometry and helpers shared by the Pong datapath blocks
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        POINT = 2'd3
    } state_t;

    localparam int COORD_W      = 10;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BALL_R       = 2;
    localparam int SPEED        = 2;
    localparam int MAX_SPEED    = 6;
    localparam int TOP_Y        = 8;
    localparam int BOT_Y        = 471;
    localparam int LPAD_X       = 36;
    localparam int RPAD_X       = 603;
    localparam int PADDLE_H     = 48;
    localparam int SERVE_FRAMES = 60;
    localparam int POINT_FRAMES = 90;

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// ball_engine_if: video timing, paddle and ball/score signals between the Pong datapath and the ball engine
interface ball_engine_if #(
    parameter int COORD_W = 10
);

    logic [COORD_W-1:0] hcount, vcount, pad_l_y, pad_r_y, ball_x, ball_y;
    logic vsync, start, ball_px, score_l, score_r;
    logic [1:0] state;

    modport master (
        output hcount, vcount, vsync, start, pad_l_y, pad_r_y,
        input  ball_px, ball_x, ball_y, score_l, score_r, state
    );

    modport slave (
        input  hcount, vcount, vsync, start, pad_l_y, pad_r_y,
        output ball_px, ball_x, ball_y, score_l, score_r, state
    );

endinterface

// File: rtl/ball_engine_frame_tick.sv
// frame_tick: registers raw vsync and emits a one-clock pulse on its falling edge
module frame_tick (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vs_q;

    // previous vsync level; cleared on reset so no spurious tick follows reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vs_q <= 1'b0;
        else vs_q <= vsync;
    end

    assign tick = vs_q & ~vsync;

endmodule

// File: rtl/ball_engine.sv
// ball_engine: per-frame ball motion, wall/paddle reflection, scoring FSM and registered ball pixel; macro BALL_SPEEDUP_EN enables per-hit speed-up
module ball_engine #(
    parameter int COORD_W      = pong_pkg::COORD_W,
    parameter int H_ACTIVE     = pong_pkg::H_ACTIVE,
    parameter int V_ACTIVE     = pong_pkg::V_ACTIVE,
    parameter int BALL_R       = pong_pkg::BALL_R,
    parameter int SPEED        = pong_pkg::SPEED,
    parameter int MAX_SPEED    = pong_pkg::MAX_SPEED,
    parameter int TOP_Y        = pong_pkg::TOP_Y,
    parameter int BOT_Y        = pong_pkg::BOT_Y,
    parameter int LPAD_X       = pong_pkg::LPAD_X,
    parameter int RPAD_X       = pong_pkg::RPAD_X,
    parameter int PADDLE_H     = pong_pkg::PADDLE_H,
    parameter int SERVE_FRAMES = pong_pkg::SERVE_FRAMES,
    parameter int POINT_FRAMES = pong_pkg::POINT_FRAMES
) (
    input logic clk,
    input logic reset,
    ball_engine_if.slave bus
);

    import pong_pkg::*;

    localparam int NW    = COORD_W + 2;
    localparam int SW    = $clog2(MAX_SPEED + 2);
    localparam int CNT_W = $clog2((SERVE_FRAMES > POINT_FRAMES ? SERVE_FRAMES : POINT_FRAMES) + 1);
    localparam logic [COORD_W-1:0] CX = COORD_W'(H_ACTIVE / 2);
    localparam logic [COORD_W-1:0] CY = COORD_W'(V_ACTIVE / 2);

    state_t st, nst;
    logic tick, serve_done, point_done, hit_top, hit_bot, hit_l, hit_r, miss_l, miss_r;
    logic dx_neg, dy_neg, ball_px, score_l, score_r;
    logic [COORD_W-1:0] x, y;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0] spd;
    logic signed [NW-1:0] v, nx, ny;
    int x_n, y_n;

    frame_tick u_tick (
        .clk  (clk),
        .reset(reset),
        .vsync(bus.vsync),
        .tick (tick)
    );

    // candidate position one frame ahead plus every collision/miss it produces
    always_comb begin
        v          = $signed({{(NW-SW){1'b0}}, spd});
        nx         = dx_neg ? $signed({2'b00, x}) - v : $signed({2'b00, x}) + v;
        ny         = dy_neg ? $signed({2'b00, y}) - v : $signed({2'b00, y}) + v;
        hit_top    = int'(ny) - BALL_R < TOP_Y;
        hit_bot    = int'(ny) + BALL_R > BOT_Y;
        hit_l      = dx_neg && int'(nx) - BALL_R <= LPAD_X && int'(x) - BALL_R > LPAD_X && iabs(int'(ny) - int'(bus.pad_l_y)) <= PADDLE_H / 2 + BALL_R;
        hit_r      = !dx_neg && int'(nx) + BALL_R >= RPAD_X && int'(x) + BALL_R < RPAD_X && iabs(int'(ny) - int'(bus.pad_r_y)) <= PADDLE_H / 2 + BALL_R;
        miss_l     = !hit_l && int'(nx) - BALL_R <= 0;
        miss_r     = !hit_r && int'(nx) + BALL_R >= H_ACTIVE - 1;
        x_n        = hit_l ? LPAD_X + BALL_R + 1 : hit_r ? RPAD_X - BALL_R - 1 : int'(nx);
        y_n        = hit_top ? TOP_Y + BALL_R : hit_bot ? BOT_Y - BALL_R : int'(ny);
        serve_done = cnt == CNT_W'(SERVE_FRAMES - 1);
        point_done = cnt == CNT_W'(POINT_FRAMES - 1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else st <= nst;
    end

    // FSM next state: start leaves IDLE, everything else advances on frame ticks
    always_comb begin
        nst = (st == IDLE && bus.start) ? SERVE :
              (st == SERVE && tick && serve_done) ? PLAY :
              (st == PLAY && tick && (miss_l || miss_r)) ? POINT :
              (st == POINT && tick && point_done) ? SERVE : st;
    end

    // FSM outputs and ball state seen by the rest of the datapath
    always_comb begin
        bus.state   = st;
        bus.ball_x  = x;
        bus.ball_y  = y;
        bus.ball_px = ball_px;
        bus.score_l = score_l;
        bus.score_r = score_r;
    end

    // ball position, direction, frame counter, score pulses and pixel hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x       <= CX;
            y       <= CY;
            dx_neg  <= 1'b0;
            dy_neg  <= 1'b0;
            cnt     <= '0;
            score_l <= 1'b0;
            score_r <= 1'b0;
            ball_px <= 1'b0;
        end else begin
            score_l <= 1'b0;
            score_r <= 1'b0;
            ball_px <= st != IDLE && iabs(int'(bus.hcount) - int'(x)) <= BALL_R && iabs(int'(bus.vcount) - int'(y)) <= BALL_R;
            if (st == IDLE) begin
                cnt <= '0;
                x   <= CX;
                y   <= CY;
            end else if (tick && st == PLAY) begin
                x       <= (miss_l || miss_r) ? x : COORD_W'(x_n);
                y       <= COORD_W'(y_n);
                dy_neg  <= hit_top ? 1'b0 : hit_bot ? 1'b1 : dy_neg;
                dx_neg  <= miss_l ? 1'b1 : miss_r ? 1'b0 : hit_l ? 1'b0 : hit_r ? 1'b1 : dx_neg;
                score_r <= miss_l;
                score_l <= miss_r;
                cnt     <= '0;
            end else if (tick) begin
                cnt <= (st == SERVE ? serve_done : point_done) ? '0 : cnt + 1'b1;
                if (st == POINT && point_done) begin
                    x <= CX;
                    y <= CY;
                end
            end
        end
    end

`ifdef BALL_SPEEDUP_EN
    // speed grows by one per paddle hit up to the cap, and returns to base on every serve
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) spd <= SW'(SPEED);
        else if (st == IDLE || (tick && st == POINT && point_done)) spd <= SW'(SPEED);
        else if (tick && st == PLAY && (hit_l || hit_r)) spd <= (spd >= SW'(MAX_SPEED)) ? SW'(MAX_SPEED) : spd + 1'b1;
    end
`else
    assign spd = SW'(SPEED);
`endif

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed checks of reset, serve timing, wall/paddle reflection, scoring and ball pixel
module tb_ball_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    int nsl = 0;
    int nsr = 0;

    ball_engine_if #(.COORD_W(10)) bus ();

    ball_engine dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // tally every cycle a score pulse is high, to prove pulses are exactly one clock
    always @(negedge clk) begin
        if (bus.score_l) nsl++;
        if (bus.score_r) nsr++;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 bus.vsync = 1'b1;
            @(posedge clk);
            #1 bus.vsync = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_ball(input string tag, input int ex, input int ey);
        check({tag, "_x"}, int'(bus.ball_x), ex);
        check({tag, "_y"}, int'(bus.ball_y), ey);
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.vsync   = 1'b0;
        bus.start   = 1'b0;
        bus.hcount  = '0;
        bus.vcount  = '0;
        bus.pad_l_y = 10'd162;
        bus.pad_r_y = 10'd420;
        #2 reset = 1'b0;
        #1;
        check("rst_state", int'(bus.state), 0);
        chk_ball("rst_ball", 320, 240);
        check("rst_px", int'(bus.ball_px), 0);
        check("rst_sl", int'(bus.score_l), 0);
        check("rst_sr", int'(bus.score_r), 0);
        step(2);
        reset = 1'b1;
        bus.hcount = 10'd320;
        bus.vcount = 10'd240;
        step(1);
        check("idle_px", int'(bus.ball_px), 0);
        frames(2);
        check("idle_stay", int'(bus.state), 0);
        chk_ball("idle_ball", 320, 240);
        // game 1: right paddle returns the ball, left paddle at pad_l_y=162 returns it too
        press_start();
        check("serve_state", int'(bus.state), 1);
        bus.hcount = 10'd322;
        bus.vcount = 10'd238;
        step(1);
        check("px_edge", int'(bus.ball_px), 1);
        bus.hcount = 10'd323;
        step(1);
        check("px_out", int'(bus.ball_px), 0);
        frames(59);
        check("serve_59", int'(bus.state), 1);
        frames(1);
        check("play_enter", int'(bus.state), 2);
        chk_ball("launch0", 320, 240);
        frames(1);
        chk_ball("launch1", 322, 242);
        frames(113);
        chk_ball("pre_bot", 548, 468);
        frames(1);
        chk_ball("bot_clamp", 550, 469);
        frames(1);
        chk_ball("bot_after", 552, 467);
        frames(24);
        chk_ball("pre_rpad", 600, 419);
        frames(1);
        chk_ball("rpad_hit", 600, 417);
        frames(1);
        chk_ball("rpad_after", 598, 415);
        frames(202);
        chk_ball("pre_top", 194, 11);
        frames(1);
        chk_ball("top_clamp", 192, 10);
        frames(1);
        chk_ball("top_after", 190, 12);
        frames(75);
        chk_ball("pre_lpad", 40, 162);
        frames(1);
        chk_ball("lpad_hit", 39, 164);
        frames(1);
        chk_ball("lpad_after", 41, 166);
        bus.hcount = 10'd41;
        bus.vcount = 10'd166;
        step(1);
        check("play_px", int'(bus.ball_px), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_state", int'(bus.state), 0);
        chk_ball("mid_rst_ball", 320, 240);
        check("mid_rst_sl", int'(bus.score_l), 0);
        check("mid_rst_sr", int'(bus.score_r), 0);
        step(1);
        check("mid_rst_px", int'(bus.ball_px), 0);
        reset = 1'b1;
        step(1);
        // game 2: left paddle 60 lines below the ball so the ball escapes left
        bus.pad_l_y = 10'd222;
        press_start();
        frames(60);
        check("g2_play", int'(bus.state), 2);
        frames(439);
        chk_ball("pre_score", 4, 198);
        check("pre_score_state", int'(bus.state), 2);
        check("pre_score_cnt", nsr, 0);
        frames(1);
        check("score_r_pulse", int'(bus.score_r), 1);
        check("score_l_quiet", int'(bus.score_l), 0);
        check("point_state", int'(bus.state), 3);
        step(1);
        check("score_r_drop", int'(bus.score_r), 0);
        check("score_r_once", nsr, 1);
        frames(89);
        check("point_hold", int'(bus.state), 3);
        frames(1);
        check("reserve", int'(bus.state), 1);
        chk_ball("reserve_ball", 320, 240);
        frames(59);
        check("reserve_hold", int'(bus.state), 1);
        frames(1);
        check("replay", int'(bus.state), 2);
        frames(1);
        chk_ball("relaunch", 318, 242);
        check("sr_total", nsr, 1);
        check("sl_total", nsl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
